// File: rtl/maze_solver_ctrl.sv
// Depth-first maze search over a 2^N x 2^N single-bit maze memory.
// Visited cells are marked in place, and the direction stack is replayed as the path.
module maze_solver_ctrl #(
  parameter int N      = 4,
  parameter int GOAL_X = 15,
  parameter int GOAL_Y = 15,
  parameter int DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] X,
  output logic [N-1:0] Y,
  output logic         D_in,
  output logic         RD,
  output logic         WR,
  input  logic         D_out,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [1:0]   move,
  output logic         move_valid
);
  localparam int SPW = 2*N + 1;
  localparam logic [N-1:0] MAXC = '1;
  localparam logic [N-1:0] GX   = N'(GOAL_X);
  localparam logic [N-1:0] GY   = N'(GOAL_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MARK, S_TRY, S_POP, S_REPLAY, S_DONE, S_FAIL
  } state_t;

  state_t           state, next_state;
  logic [N-1:0]     cur_x, cur_y;
  logic [2:0]       dir;
  logic [SPW-1:0]   sp, idx, sp_m1;
  logic [1:0]       stack [DEPTH];
  logic [1:0]       top;
  logic [N-1:0]     nb_x, nb_y, pop_x, pop_y;
  logic             nb_ok, push, at_goal;

  assign sp_m1   = sp - 1'b1;
  assign top     = stack[sp_m1[SPW-2:0]];
  assign at_goal = (cur_x == GX) && (cur_y == GY);
  assign push    = (state == S_TRY) && !dir[2] && nb_ok && !D_out;

  // Neighbour in the current direction; nb_ok is low at the grid edge.
  always_comb begin
    nb_x  = cur_x;
    nb_y  = cur_y;
    nb_ok = 1'b0;
    case (dir)
      3'd0:    begin nb_y = cur_y + 1'b1; nb_ok = (cur_y != MAXC); end
      3'd1:    begin nb_x = cur_x + 1'b1; nb_ok = (cur_x != MAXC); end
      3'd2:    begin nb_y = cur_y - 1'b1; nb_ok = (cur_y != '0);   end
      3'd3:    begin nb_x = cur_x - 1'b1; nb_ok = (cur_x != '0);   end
      default: ;
    endcase
  end

  // Step back against the direction that was pushed.
  always_comb begin
    pop_x = cur_x;
    pop_y = cur_y;
    case (top)
      2'd0: pop_y = cur_y - 1'b1;
      2'd1: pop_x = cur_x - 1'b1;
      2'd2: pop_y = cur_y + 1'b1;
      2'd3: pop_x = cur_x + 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) next_state = S_CHECK;
      S_CHECK:  next_state = D_out ? S_FAIL : S_MARK;
      S_MARK:   next_state = at_goal ? S_REPLAY : S_TRY;
      S_TRY: begin
        if (dir[2])    next_state = (sp == '0) ? S_FAIL : S_POP;
        else if (push) next_state = S_MARK;
      end
      S_POP:    next_state = S_TRY;
      S_REPLAY: if (sp == '0 || idx == sp_m1) next_state = S_DONE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x <= '0;
      cur_y <= '0;
      dir   <= '0;
      sp    <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: if (start) begin
          cur_x <= '0;
          cur_y <= '0;
          sp    <= '0;
        end
        S_MARK: begin
          if (at_goal) idx <= '0;
          else         dir <= '0;
        end
        S_TRY: if (!dir[2]) begin
          if (push) begin
            sp    <= sp + 1'b1;
            cur_x <= nb_x;
            cur_y <= nb_y;
          end else begin
            dir <= dir + 1'b1;
          end
        end
        S_POP: begin
          sp    <= sp_m1;
          cur_x <= pop_x;
          cur_y <= pop_y;
          dir   <= {1'b0, top} + 3'd1;
        end
        S_REPLAY: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[sp[SPW-2:0]] <= dir[1:0];
  end

  always_comb begin
    X          = '0;
    Y          = '0;
    D_in       = 1'b0;
    RD         = 1'b0;
    WR         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    move       = '0;
    move_valid = 1'b0;
    unique case (state)
      S_CHECK: begin
        busy = 1'b1;
        RD   = 1'b1;
        X    = cur_x;
        Y    = cur_y;
      end
      S_MARK: begin
        busy = 1'b1;
        WR   = 1'b1;
        D_in = 1'b1;
        X    = cur_x;
        Y    = cur_y;
      end
      S_TRY: begin
        busy = 1'b1;
        if (!dir[2] && nb_ok) begin
          RD = 1'b1;
          X  = nb_x;
          Y  = nb_y;
        end
      end
      S_POP: busy = 1'b1;
      S_REPLAY: begin
        busy = 1'b1;
        if (sp != '0) begin
          move       = stack[idx[SPW-2:0]];
          move_valid = 1'b1;
        end
      end
      S_DONE:  done = 1'b1;
      S_FAIL:  fail = 1'b1;
      default: ;
    endcase
  end
endmodule
